dram_responder: RTL and testbench
=================================

DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL provide parameter LATENCY, default 2: wait cycles inserted between request acceptance and response (0..15).
REQ-002 SHALL provide parameter DEPTH_LOG2, default 10: log2 of storage depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  1  CPU request valid.
REQ-006 SHALL have port wr  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr  input  32  byte address; word index = addr[DEPTH_LOG2+1:2].
REQ-008 SHALL have port wstrb  input  4  byte write enables; bit i covers wdata[8i+7:8i].
REQ-009 SHALL have port wdata  input  32  write data.
REQ-010 SHALL have port addr_ok  output  1  request accepted this cycle when req is also high.
REQ-011 SHALL have port data_ok  output  1  one-cycle response strobe.
REQ-012 SHALL have port rdata  output  32  read data; valid only while data_ok is high.
REQ-013 SHALL have port busy  output  1  transaction outstanding; drives the CPU's d_stall.
REQ-014 SHALL have port err  output  1  address-range error; valid with data_ok (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; at most one outstanding transaction.
REQ-016 addr_ok SHALL equal (state==IDLE), combinationally; no request is accepted in WAIT or RESP.
REQ-017 On req & addr_ok at cycle T: SHALL latch wr, addr, wstrb, wdata; load the wait counter with LATENCY; next state WAIT if LATENCY>0, else RESP.
REQ-018 In WAIT: SHALL decrement the counter each cycle; when the counter is 1, next state is RESP.
REQ-019 data_ok SHALL be high exactly in the RESP cycle, i.e. at cycle T+LATENCY+1; RESP always returns to IDLE next cycle.
REQ-020 Write: bytes with latched wstrb set SHALL be stored at the RESP clock edge; other bytes SHALL be unchanged; rdata is don't-care.
REQ-021 Read: rdata SHALL be the full stored word at the latched index; size and byte selection are the CPU's job.
REQ-022 A write with wstrb=4'b0000 SHALL complete normally with no storage change.
REQ-023 busy SHALL be (state!=IDLE) || (req & addr_ok); a read immediately after a write SHALL return the written data.
REQ-024 Inputs SHALL be ignored outside the acceptance cycle; changes to addr or wdata during WAIT have no effect.
REQ-025 Without the range check, the address SHALL wrap modulo 2^DEPTH_LOG2 words; bits above the index are ignored.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, data_ok 0, rdata 0, err 0, and busy 0 on the next edge.
REQ-027 Reset while in WAIT SHALL abort the transaction: no write is committed and no data_ok is issued.
REQ-028 Storage contents SHALL NOT be cleared by rst; they are initialised to zero at time zero only.

Configuration
REQ-029 Macro DRAM_RESP_ADDR_CHECK_EN, when defined: any address with a nonzero bit in addr[31:DEPTH_LOG2+2] SHALL raise err with data_ok, suppress the write, and return rdata=0.
REQ-030 Macro DRAM_RESP_ADDR_CHECK_EN, when undefined: err SHALL be tied 0 and the address wraps per REQ-025.

Verification
REQ-031 LATENCY=2; write addr=0x10, wstrb=F, wdata=0xDEADBEEF at cycle 0 -> addr_ok=1 at cycle 0, busy cycles 0-3, data_ok only at cycle 3; read 0x10 -> rdata=0xDEADBEEF.
REQ-032 Partial write: preload 0x11223344 at 0x20; write wstrb=0101, wdata=0xAABBCCDD -> read returns 0x11BB33DD.
REQ-033 LATENCY=0: read request at cycle 0 -> data_ok at cycle 1; back-to-back req held high -> one accept every 2 cycles, never during RESP.
REQ-034 Reset in WAIT after a write of 0x55 to 0x40 -> no data_ok, busy=0 next cycle, word at 0x40 unchanged (0).
REQ-035 DEPTH_LOG2=10, write 0x1000_0004 -> without macro, aliases word 1 (read 0x4 returns the data); with DRAM_RESP_ADDR_CHECK_EN, err=1 with data_ok and word 1 is unchanged.

Source files
------------

// File: rtl/dram_responder.sv
// Single-port word memory that answers one CPU request at a time after LATENCY wait cycles.
// Optional macro DRAM_RESP_ADDR_CHECK_EN flags out-of-range addresses instead of wrapping them.
module dram_responder #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   accept;
  logic                   wr_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [DEPTH_LOG2-1:0]  rd_idx;
  logic [3:0]             wstrb_q;
  logic [31:0]            wdata_q;
  logic                   range_err;
  logic                   range_err_q;
  logic                   mem_we;
  logic [31:0]            ram_rd;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^{addr[1:0], addr[31:DEPTH_LOG2+2]};

`ifdef DRAM_RESP_ADDR_CHECK_EN
  assign range_err = |addr[31:DEPTH_LOG2+2];
`else
  assign range_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = LAT_INIT;
          state_d = (LATENCY > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    addr_ok = (state_q == IDLE);
    data_ok = (state_q == RESP);
    accept  = req && (state_q == IDLE);
    busy    = (state_q != IDLE) || (req && (state_q == IDLE));
    err     = (state_q == RESP) && range_err_q;
    rdata   = ((state_q == RESP) && !range_err_q) ? ram_rd : 32'd0;
  end

  // Request capture; inputs are only looked at in the acceptance cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wstrb_q     <= 4'd0;
      wdata_q     <= 32'd0;
      range_err_q <= 1'b0;
    end else if (accept) begin
      wr_q        <= wr;
      idx_q       <= addr[DEPTH_LOG2+1:2];
      wstrb_q     <= wstrb;
      wdata_q     <= wdata;
      range_err_q <= range_err;
    end
  end

  // With LATENCY=0 the RAM read must start from the live address in the accept cycle
  assign rd_idx = (state_q == IDLE) ? addr[DEPTH_LOG2+1:2] : idx_q;
  assign mem_we = (state_q == RESP) && wr_q && !range_err_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_q [DEPTH] = '{default: 8'd0};
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk) begin
        if (mem_we && wstrb_q[gi]) lane_q[idx_q] <= wdata_q[8*gi +: 8];
        lane_rd_q <= lane_q[rd_idx];
      end

      assign ram_rd[8*gi +: 8] = lane_rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_dram_responder.sv
// Directed self-checking bench for dram_responder: default LATENCY=2 instance plus a LATENCY=0 instance.
module tb_dram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok, busy, err;
  logic [31:0] rdata;

  logic        req0, wr0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  wstrb0;
  logic        addr_ok0, data_ok0, busy0, err0;
  logic [31:0] rdata0;

  int          tests = 0;
  int          fails = 0;
  int          lat_seen;
  logic [31:0] rdata_seen;
  logic        err_seen;

  always #5 clk = ~clk;

  dram_responder #(.LATENCY(2), .DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .busy(busy), .err(err)
  );

  dram_responder #(.LATENCY(0), .DEPTH_LOG2(10)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .wr(wr0), .addr(addr0), .wstrb(wstrb0),
    .wdata(wdata0), .addr_ok(addr_ok0), .data_ok(data_ok0), .rdata(rdata0),
    .busy(busy0), .err(err0)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance; inputs are scrambled after acceptance
  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int n;
    req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
    #1;
    chk("accept_addr_ok", addr_ok, 1);
    tick;
    req = 1'b0; wr = ~w; addr = ~a; wstrb = ~s; wdata = ~d;
    #1;
    n = 1;
    while (!data_ok && n < 20) begin
      tick; #1; n++;
    end
    lat_seen   = n;
    rdata_seen = rdata;
    err_seen   = err;
    $display("[TB] txn wr=%0b addr=%h wstrb=%b wdata=%h -> cycle %0d rdata=%h err=%0b",
             w, a, s, d, n, rdata_seen, err_seen);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wstrb0 = '0; wdata0 = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_data_ok", data_ok, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_addr_ok", addr_ok, 1);
    chk("rst_rdata",   rdata, 0);
    chk("rst_err",     err, 0);

    // LATENCY=0: request held high is accepted every other cycle
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10; wstrb0 = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      $display("[TB] lat0 cycle %0d addr_ok=%0b data_ok=%0b busy=%0b", i, addr_ok0, data_ok0, busy0);
      chk($sformatf("lat0_addr_ok_c%0d", i), addr_ok0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("lat0_data_ok_c%0d", i), data_ok0, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("lat0_busy_c%0d", i), busy0, 1);
      if (i % 2 == 1) chk("lat0_rdata_zero", rdata0, 0);
      tick;
    end
    req0 = 1'b0;
    #1;
    chk("lat0_idle_busy", busy0, 0);

    // LATENCY=0: write immediately followed by a read of the same word
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h12345678; wstrb0 = 4'hF;
    tick;
    wr0 = 1'b0; wdata0 = 32'h0;
    #1;
    chk("lat0_wr_data_ok", data_ok0, 1);
    tick;
    #1;
    chk("lat0_rd_accept", addr_ok0, 1);
    tick;
    req0 = 1'b0;
    #1;
    chk("lat0_rd_data_ok", data_ok0, 1);
    chk("lat0_raw_rdata", rdata0, 32'h12345678);
    chk("lat0_err", err0, 0);
    tick;

    // Cycle-accurate write timing at LATENCY=2
    req = 1'b1; wr = 1'b1; addr = 32'h10; wstrb = 4'hF; wdata = 32'hDEADBEEF;
    #1;
    chk("c0_addr_ok", addr_ok, 1);
    chk("c0_busy",    busy, 1);
    chk("c0_data_ok", data_ok, 0);
    tick;
    req = 1'b0; addr = 32'h44; wdata = 32'h0BADF00D;
    for (int c = 1; c <= 4; c++) begin
      #1;
      $display("[TB] lat2 cycle %0d addr_ok=%0b data_ok=%0b busy=%0b", c, addr_ok, data_ok, busy);
      chk($sformatf("c%0d_data_ok", c), data_ok, (c == 3) ? 1 : 0);
      chk($sformatf("c%0d_busy", c), busy, (c <= 3) ? 1 : 0);
      chk($sformatf("c%0d_addr_ok", c), addr_ok, (c == 4) ? 1 : 0);
      tick;
    end

    txn(1'b0, 32'h10, 4'h0, 32'h0);
    chk("rd10_latency", lat_seen, 3);
    chk("rd10_rdata", rdata_seen, 32'hDEADBEEF);
    chk("rd10_err", err_seen, 0);

    // Partial write
    txn(1'b1, 32'h20, 4'hF, 32'h11223344);
    chk("pre20_latency", lat_seen, 3);
    txn(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    txn(1'b0, 32'h20, 4'h0, 32'h0);
    chk("partial_rdata", rdata_seen, 32'h11BB33DD);

    // Zero-strobe write completes but changes nothing
    txn(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF);
    chk("wstrb0_latency", lat_seen, 3);
    txn(1'b0, 32'h20, 4'h0, 32'h0);
    chk("wstrb0_rdata", rdata_seen, 32'h11BB33DD);

    // Reset during WAIT aborts the write
    req = 1'b1; wr = 1'b1; addr = 32'h40; wstrb = 4'hF; wdata = 32'h55;
    tick;
    req = 1'b0; rst = 1'b1;
    #1;
    chk("abort_wait_data_ok", data_ok, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_addr_ok", addr_ok, 1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort_no_data_ok_%0d", c), data_ok, 0);
      tick; #1;
    end
    txn(1'b0, 32'h40, 4'h0, 32'h0);
    chk("abort_word40", rdata_seen, 32'h0);

    // Address above the index range
    txn(1'b1, 32'h1000_0004, 4'hF, 32'hCAFEF00D);
    chk("hi_wr_latency", lat_seen, 3);
`ifdef DRAM_RESP_ADDR_CHECK_EN
    chk("hi_wr_err", err_seen, 1);
    txn(1'b0, 32'h4, 4'h0, 32'h0);
    chk("hi_word1_unchanged", rdata_seen, 32'h0);
    chk("hi_word1_err", err_seen, 0);
    txn(1'b0, 32'h1000_0004, 4'h0, 32'h0);
    chk("hi_rd_err", err_seen, 1);
    chk("hi_rd_rdata", rdata_seen, 32'h0);
`else
    chk("hi_wr_err", err_seen, 0);
    txn(1'b0, 32'h4, 4'h0, 32'h0);
    chk("hi_alias_word1", rdata_seen, 32'hCAFEF00D);
    txn(1'b0, 32'h8000_1004, 4'h0, 32'h0);
    chk("hi_alias_read", rdata_seen, 32'hCAFEF00D);
    chk("hi_alias_err", err_seen, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
